// File: rtl/ram_ctrl_pkg.sv
// Shared op codes, state encoding and default widths for the RAM block sequencer.
package ram_ctrl_pkg;

  localparam int DEF_BUS_WIDTH  = 14;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_FILL = 2'b00,
    OP_COPY = 2'b01,
    OP_READ = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_CP_RD,
    S_CP_WR,
    S_RD_ISS,
    S_RD_CAP,
    S_RD_OUT,
    S_DONE
  } state_e;

endpackage

// File: rtl/ram_ctrl_rd_buf.sv
// Single-entry output register for READ words: loads on request, holds data
// stable until the consumer takes it with valid&&ready.
module ram_ctrl_rd_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ram_ctrl.sv
// Block-command sequencer (FILL/COPY/READ) for the single-port synchronous RAM.
// Optional RAM_CTRL_SUM_EN adds a running sum of all words written or handed out.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [BUS_WIDTH-1:0]  cmd_src,
  input  logic [BUS_WIDTH-1:0]  cmd_dst,
  input  logic [BUS_WIDTH:0]    cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BUS_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready
`ifdef RAM_CTRL_SUM_EN
  ,
  output logic [DATA_WIDTH-1:0] sum
`endif
);

  localparam int LW = BUS_WIDTH + 1;

  state_e                state_q, state_d;
  logic [BUS_WIDTH-1:0]  src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [LW-1:0]         len_q, len_d, cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, wdata_q, wdata_d;
  logic                  we_q, we_d, rsvd_q, rsvd_d;
  logic [LW-1:0]         cnt_inc;
  logic                  accept, last, rd_hs;

  assign accept  = cmd_valid && (state_q == S_IDLE);
  assign cnt_inc = cnt_q + LW'(1);
  assign last    = (cnt_inc == len_q);
  assign rd_hs   = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rsvd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rsvd_q  <= rsvd_d;
    end
  end

  // RAM pins are registered, so each branch computes the pin values for the state being entered.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    rsvd_d  = rsvd_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          src_d  = cmd_src;
          dst_d  = cmd_dst;
          len_d  = cmd_len;
          data_d = cmd_data;
          cnt_d  = '0;
          rsvd_d = (op_e'(cmd_op) == OP_RSVD);
          if (cmd_len == '0) begin
            state_d = S_DONE;
          end else begin
            case (op_e'(cmd_op))
              OP_FILL: begin
                state_d = S_FILL;
                addr_d  = cmd_dst;
                wdata_d = cmd_data;
                we_d    = 1'b1;
              end
              OP_COPY: begin
                state_d = S_CP_RD;
                addr_d  = cmd_src;
              end
              OP_READ: begin
                state_d = S_RD_ISS;
                addr_d  = cmd_src;
              end
              default: state_d = S_DONE;
            endcase
          end
        end
      end
      S_FILL: begin
        if (last) begin
          state_d = S_DONE;
        end else begin
          cnt_d  = cnt_inc;
          addr_d = dst_q + cnt_inc[BUS_WIDTH-1:0];
          we_d   = 1'b1;
        end
      end
      S_CP_RD: begin
        state_d = S_CP_WR;
        addr_d  = dst_q + cnt_q[BUS_WIDTH-1:0];
        we_d    = 1'b1;
      end
      S_CP_WR: begin
        wdata_d = mem_rdata;
        if (last) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CP_RD;
          cnt_d   = cnt_inc;
          addr_d  = src_q + cnt_inc[BUS_WIDTH-1:0];
        end
      end
      S_RD_ISS: state_d = S_RD_CAP;
      S_RD_CAP: state_d = S_RD_OUT;
      S_RD_OUT: begin
        if (rd_hs) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD_ISS;
            cnt_d   = cnt_inc;
            addr_d  = src_q + cnt_inc[BUS_WIDTH-1:0];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  ram_ctrl_rd_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_q == S_RD_CAP),
    .data_i (mem_rdata),
    .ready_i(rd_ready),
    .valid_o(rd_valid),
    .data_o (rd_data)
  );

  // Copy write data comes straight from the RAM's registered output of the previous cycle.
  assign mem_wdata = (state_q == S_CP_WR) ? mem_rdata : wdata_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = done && rsvd_q;

`ifdef RAM_CTRL_SUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (accept) begin
      sum_d = '0;
    end else if (state_q == S_FILL || state_q == S_CP_WR) begin
      sum_d = sum_q + mem_wdata;
    end else if (state_q == S_RD_OUT && rd_hs) begin
      sum_d = sum_q + rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign sum = sum_q;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl with a behavioural single-port RAM attached.
module tb_ram_ctrl;
  import ram_ctrl_pkg::*;

  localparam int BW = 14;
  localparam int DW = 32;

  typedef struct packed {
    logic          we;
    logic [BW-1:0] addr;
    logic [DW-1:0] data;
  } memOp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [BW-1:0] cmd_src = '0;
  logic [BW-1:0] cmd_dst = '0;
  logic [BW:0]   cmd_len = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          busy, done, err;
  logic [BW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready = 1'b1;
`ifdef RAM_CTRL_SUM_EN
  logic [DW-1:0] sum;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  memOp_t        expQ[$];
  logic [DW-1:0] rdQ[$];
  logic [DW-1:0] ram [0:(2**BW)-1];

  always #5 clk = ~clk;

  // Registered-read RAM model matching the target RAM's one-cycle latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  ram_ctrl #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_src  (cmd_src),
    .cmd_dst  (cmd_dst),
    .cmd_len  (cmd_len),
    .cmd_data (cmd_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready)
`ifdef RAM_CTRL_SUM_EN
    ,
    .sum      (sum)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one command; returns positioned in cycle 1 after the accept edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [BW-1:0] src,
                               input logic [BW-1:0] dst, input logic [BW:0] len,
                               input logic [DW-1:0] data);
    int waitCnt = 0;
    while (cmd_ready !== 1'b1 && waitCnt < 50) begin
      tick();
      waitCnt++;
    end
    if (cmd_ready !== 1'b1) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL cmd_ready_timeout got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = len;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles, output int cycles);
    cycles = 1;
    while (done !== 1'b1 && cycles < maxCycles) begin
      tick();
      cycles++;
    end
    if (done !== 1'b1) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL done_timeout got done=%b after %0d cycles", done, cycles);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    testsRun++;
    if ({busy, done, err, mem_we, rd_valid} !== 5'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || rd_data !== '0 || cmd_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_state got busy=%b done=%b err=%b we=%b rdv=%b addr=%h wdata=%h rdata=%h rdy=%b want all 0 and rdy=1",
               busy, done, err, mem_we, rd_valid, mem_addr, mem_wdata, rd_data, cmd_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_wrap();
    logic [BW-1:0] a;
    memOp_t e;
    a = 14'h3FFE;
    for (int i = 0; i < 4; i++) begin
      expQ.push_back({1'b1, a, 32'hA5A5A5A5});
      a = a + 14'd1;
    end
    applyStimulus(OP_FILL, '0, 14'h3FFE, 15'd4, 32'hA5A5A5A5);
    for (int c = 1; c <= 4; c++) begin
      e = expQ.pop_front();
      testsRun++;
      if (mem_we !== e.we || mem_addr !== e.addr || mem_wdata !== e.data || busy !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL fill_cycle%0d got we=%b addr=%h data=%h busy=%b want we=1 addr=%h data=%h busy=1",
                 c, mem_we, mem_addr, mem_wdata, busy, e.addr, e.data);
      end
      tick();
    end
    testsRun++;
    if (done !== 1'b1 || mem_we !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL fill_done_cycle5 got done=%b we=%b want done=1 we=0", done, mem_we);
    end
    tick();
    a = 14'h3FFE;
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (ram[a] !== 32'hA5A5A5A5) begin
        testsFailed++;
        $display("[TB] FAIL fill_readback addr=%h got %h want a5a5a5a5", a, ram[a]);
      end
      a = a + 14'd1;
    end
  endtask

  task automatic test_copy();
    int cyc;
    memOp_t e;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_FILL, '0, 14'h10 + 14'(i), 15'd1, 32'(i + 1));
      waitDone(20, cyc);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      expQ.push_back({1'b0, 14'h10 + 14'(i), 32'h0});
      expQ.push_back({1'b1, 14'h20 + 14'(i), 32'(i + 1)});
    end
    applyStimulus(OP_COPY, 14'h10, 14'h20, 15'd3, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      e = expQ.pop_front();
      testsRun++;
      if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
        testsFailed++;
        $display("[TB] FAIL copy_cycle%0d got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                 c, mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
      end
      tick();
    end
    testsRun++;
    if (done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL copy_done_cycle7 got %b want 1", done);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      testsRun++;
      if (ram[14'h20 + 14'(i)] !== 32'(i + 1)) begin
        testsFailed++;
        $display("[TB] FAIL copy_readback idx=%0d got %h want %h", i, ram[14'h20 + 14'(i)], 32'(i + 1));
      end
    end
  endtask

  task automatic test_read_stall();
    int words = 0;
    int stall = 0;
    int cyc = 0;
    logic [DW-1:0] exp;
    for (int i = 1; i <= 3; i++) rdQ.push_back(32'(i));
    rd_ready = 1'b1;
    applyStimulus(OP_READ, 14'h20, '0, 15'd3, 32'h0);
    while (done !== 1'b1 && cyc < 100) begin
      if (rd_valid === 1'b1) begin
        if (rdQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL read_extra_word got %h want none", rd_data);
          rd_ready = 1'b1;
        end else if (words == 1 && stall < 5) begin
          rd_ready = 1'b0;
          stall++;
          testsRun++;
          if (rd_data !== rdQ[0]) begin
            testsFailed++;
            $display("[TB] FAIL read_stall_hold got %h want %h", rd_data, rdQ[0]);
          end
        end else begin
          rd_ready = 1'b1;
          exp = rdQ.pop_front();
          testsRun++;
          if (rd_data !== exp) begin
            testsFailed++;
            $display("[TB] FAIL read_word%0d got %h want %h", words, rd_data, exp);
          end
          words++;
        end
      end
      tick();
      cyc++;
    end
    rd_ready = 1'b1;
    testsRun++;
    if (done !== 1'b1 || words != 3 || rdQ.size() != 0 || stall != 5) begin
      testsFailed++;
      $display("[TB] FAIL read_complete got done=%b words=%0d left=%0d stalls=%0d want done=1 words=3 left=0 stalls=5",
               done, words, rdQ.size(), stall);
    end
    rdQ.delete();
    tick();
  endtask

  task automatic test_len0_rsvd();
    applyStimulus(OP_FILL, '0, 14'h40, 15'd0, 32'h77);
    testsRun++;
    if (done !== 1'b1 || err !== 1'b0 || mem_we !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL len0_fill got done=%b err=%b we=%b want done=1 err=0 we=0", done, err, mem_we);
    end
    tick();
    testsRun++;
    if (cmd_ready !== 1'b1 || ram[14'h40] === 32'h77) begin
      testsFailed++;
      $display("[TB] FAIL len0_after got rdy=%b mem=%h want rdy=1 mem not 77", cmd_ready, ram[14'h40]);
    end
    applyStimulus(OP_RSVD, '0, 14'h40, 15'd5, 32'h77);
    testsRun++;
    if (done !== 1'b1 || err !== 1'b1 || mem_we !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rsvd_op got done=%b err=%b we=%b want done=1 err=1 we=0", done, err, mem_we);
    end
    tick();
    testsRun++;
    if (err !== 1'b0 || done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rsvd_pulse got done=%b err=%b want 0 0", done, err);
    end
  endtask

  task automatic test_reset_midfill();
    applyStimulus(OP_FILL, '0, 14'h100, 15'd100, 32'h5A5A5A5A);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    testsRun++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || mem_addr !== '0) begin
      testsFailed++;
      $display("[TB] FAIL midfill_reset got we=%b busy=%b done=%b rdy=%b addr=%h want 0 0 0 1 0",
               mem_we, busy, done, cmd_ready, mem_addr);
    end
    rst_n = 1'b1;
    tick();
    testsRun++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midfill_after got rdy=%b busy=%b we=%b want 1 0 0", cmd_ready, busy, mem_we);
    end
    for (int i = 0; i < 9; i++) begin
      testsRun++;
      if (ram[14'h100 + 14'(i)] !== 32'h5A5A5A5A) begin
        testsFailed++;
        $display("[TB] FAIL midfill_kept idx=%0d got %h want 5a5a5a5a", i, ram[14'h100 + 14'(i)]);
      end
    end
    testsRun++;
    if (ram[14'h114] === 32'h5A5A5A5A) begin
      testsFailed++;
      $display("[TB] FAIL midfill_abandoned got %h want not 5a5a5a5a", ram[14'h114]);
    end
  endtask

`ifdef RAM_CTRL_SUM_EN
  task automatic test_sum();
    int cyc;
    applyStimulus(OP_FILL, '0, 14'h200, 15'd4, 32'hFFFFFFFF);
    waitDone(20, cyc);
    testsRun++;
    if (sum !== 32'hFFFFFFFC) begin
      testsFailed++;
      $display("[TB] FAIL sum_fill got %h want fffffffc", sum);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_fill_wrap();
    test_copy();
    test_read_stall();
    test_len0_rsvd();
    test_reset_midfill();
`ifdef RAM_CTRL_SUM_EN
    test_sum();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
